// File: rtl/sser_pkg.sv
// Shared SSER definitions: transmit FSM states, register offsets and STATUS bit positions.
// Used by both the transmit block and the read-side decoder.
package sser_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_e;

    localparam logic [3:0] SSER_REG_TXDATA = 4'h0;
    localparam logic [3:0] SSER_REG_STATUS = 4'h1;

    localparam int unsigned SSER_ST_BUSY      = 0;
    localparam int unsigned SSER_ST_HOLD_FULL = 1;
    localparam int unsigned SSER_ST_OVR       = 2;

endpackage

// File: rtl/sser_bit_timer.sv
// Serial bit-period divider: counts 0..BIT_DIV-1 while running and flags the last count.
// The FSM restarts it whenever a new frame is loaded so the start bit gets a full period.
module sser_bit_timer #(
    parameter int unsigned BIT_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic bit_tick
);

    localparam int unsigned W = $clog2(BIT_DIV);
    localparam logic [W-1:0] DIV_LAST = W'(BIT_DIV - 1);

    logic [W-1:0] div;

    assign bit_tick = run & (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (restart) begin
            div <= '0;
        end else if (run) begin
            div <= bit_tick ? '0 : div + W'(1);
        end
    end

endmodule

// File: rtl/sser_tx.sv
// SSER transmit side: one-byte holding register feeding an 8N1 serializer on sdwr.
// Define SSER_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module sser_tx
    import sser_pkg::*;
#(
    parameter int unsigned BIT_DIV  = 16,
    parameter logic        IDLE_LVL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sser_n,
    input  logic       ba13,
    input  logic       ba12,
    input  logic [3:0] ba,
    input  logic       br_w,
    input  logic       bus_stb,
    input  logic [7:0] bd_in,
    output logic [7:0] bd_out,
    output logic       bd_oe,
    output logic       sdwr,
    output logic       busy
);

    tx_state_e  state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic       busy_n, sdwr_n;
    logic [7:0] hold;
    logic       hold_full, ovr;
    logic       sel, wr, rd;
    logic       load, bit_tick;
`ifdef SSER_TX_PARITY_EN
    logic       par;
`endif

    assign sel = ~sser_n & ~ba13 & ba12 & bus_stb;
    assign wr  = sel & ~br_w & (ba == SSER_REG_TXDATA);
    assign rd  = sel & br_w & (ba == SSER_REG_STATUS);

    assign bd_oe = rd;
    always_comb begin
        bd_out = '0;
        if (rd) begin
            bd_out[SSER_ST_BUSY]      = busy;
            bd_out[SSER_ST_HOLD_FULL] = hold_full;
            bd_out[SSER_ST_OVR]       = ovr;
        end
    end

    sser_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (load),
        .run      (state != TX_IDLE),
        .bit_tick (bit_tick)
    );

    // sdwr_n is the level for the state being entered, so sdwr changes on the same edge as state.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        busy_n    = busy;
        sdwr_n    = sdwr;
        load      = 1'b0;
        case (state)
            TX_IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    shift_n = hold;
                    busy_n  = 1'b1;
                    sdwr_n  = ~IDLE_LVL;
                    state_n = TX_START;
                end
            end
            TX_START: begin
                if (bit_tick) begin
                    bit_idx_n = '0;
                    sdwr_n    = shift[0];
                    state_n   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef SSER_TX_PARITY_EN
                        sdwr_n  = par;
                        state_n = TX_PAR;
`else
                        sdwr_n  = IDLE_LVL;
                        state_n = TX_STOP;
`endif
                    end else begin
                        shift_n   = shift >> 1;
                        bit_idx_n = bit_idx + 3'd1;
                        sdwr_n    = shift[1];
                    end
                end
            end
`ifdef SSER_TX_PARITY_EN
            TX_PAR: begin
                if (bit_tick) begin
                    sdwr_n  = IDLE_LVL;
                    state_n = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (bit_tick) begin
                    if (hold_full) begin
                        load    = 1'b1;
                        shift_n = hold;
                        sdwr_n  = ~IDLE_LVL;
                        state_n = TX_START;
                    end else begin
                        busy_n  = 1'b0;
                        sdwr_n  = IDLE_LVL;
                        state_n = TX_IDLE;
                    end
                end
            end
            default: begin
                busy_n  = 1'b0;
                sdwr_n  = IDLE_LVL;
                state_n = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            sdwr    <= IDLE_LVL;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            busy    <= busy_n;
            sdwr    <= sdwr_n;
        end
    end

`ifdef SSER_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^hold;
        end
    end
`endif

    // A write coinciding with a load refills the slot the load is vacating, so it is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            if (wr && (!hold_full || load)) begin
                hold      <= bd_in;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (wr && hold_full && !load) begin
                ovr <= 1'b1;
            end else if (rd) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sser_tx.sv
// Self-checking bench for sser_tx: a timeline model of accepted bytes and frame start edges
// predicts sdwr, busy and STATUS every cycle under directed and random bus traffic.
module tb_sser_tx;

    localparam int BD = 4;
`ifdef SSER_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = BD * NB;
    localparam int HMAX  = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sser_n = 1'b1, ba13 = 1'b0, ba12 = 1'b0, br_w = 1'b1, bus_stb = 1'b0;
    logic [3:0] ba = '0;
    logic [7:0] bd_in = '0;
    logic [7:0] bd_out;
    logic       bd_oe, sdwr, busy;

    sser_tx #(.BIT_DIV(BD), .IDLE_LVL(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sser_n  (sser_n),
        .ba13    (ba13),
        .ba12    (ba12),
        .ba      (ba),
        .br_w    (br_w),
        .bus_stb (bus_stb),
        .bd_in   (bd_in),
        .bd_out  (bd_out),
        .bd_oe   (bd_oe),
        .sdwr    (sdwr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int         s;
        logic [7:0] b;
    } frm_t;
    frm_t       sent[$];
    bit         m_pend;
    int         m_fill;
    logic [7:0] m_byte;
    int         m_fend;
    bit         m_ovr;
    logic       hist[HMAX];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (NB == 11 && i == 9) return ^b;
        return 1'b1;
    endfunction

    // Line level and busy for cycle c: a frame loaded at edge s occupies cycles s+1..s+FRAME.
    task automatic exp_line(input int c, output logic sd, output logic bz);
        sd = 1'b1;
        bz = 1'b0;
        foreach (sent[j]) begin
            if (c >= sent[j].s + 1 && c <= sent[j].s + FRAME) begin
                sd = frame_bit(sent[j].b, (c - sent[j].s - 1) / BD);
                bz = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_ovr  = 0;
        m_fend = 0;
        m_fill = 0;
        sent.delete();
    endtask

    task automatic step(input logic s_n, input logic b13, input logic b12, input logic stb,
                        input logic rw, input logic [3:0] a, input logic [7:0] d);
        logic esd, ebz, mwr, mrd;
        int   ld;
        sser_n = s_n; ba13 = b13; ba12 = b12; bus_stb = stb; br_w = rw; ba = a; bd_in = d;
        mwr = ~s_n & ~b13 & b12 & stb & ~rw & (a == 4'h0);
        mrd = ~s_n & ~b13 & b12 & stb & rw & (a == 4'h1);
        @(negedge clk);
        exp_line(cyc, esd, ebz);
        if (cyc < HMAX) hist[cyc] = sdwr;
        check("sdwr", 32'(sdwr), 32'(esd));
        check("busy", 32'(busy), 32'(ebz));
        check("bd_oe", 32'(bd_oe), 32'(mrd));
        if (mrd) check("status", 32'(bd_out), {29'd0, m_ovr, m_pend, ebz});
        @(posedge clk);
        ld = (m_fill + 1 > m_fend) ? m_fill + 1 : m_fend;
        if (m_pend && cyc >= ld) begin
            sent.push_back('{cyc, m_byte});
            m_fend = cyc + FRAME;
            m_pend = 0;
        end
        if (mwr) begin
            if (m_pend) m_ovr = 1;
            else begin
                m_pend = 1; m_fill = cyc; m_byte = d;
            end
        end
        if (mrd) m_ovr = 0;
        while (sent.size() > 0 && sent[0].s + FRAME + 2 < cyc) void'(sent.pop_front());
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, d);
    endtask

    task automatic rd_status();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 8'h00);
    endtask

    initial begin
        int         n0;
        logic [9:0] cap;
        logic [7:0] rb;
        int         r;

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_sdwr", 32'(sdwr), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'(bd_oe), 32'd0);
        check("rst_bd_out", 32'(bd_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        // 8'hA5 waveform, LSB first
        n0 = cyc;
        wr_byte(8'hA5);
        idle(FRAME + 6);
        for (int i = 0; i < 10; i++) cap[i] = hist[n0 + 2 + BD * i + 1];
`ifdef SSER_TX_PARITY_EN
        check("a5_bits", 32'({cap[8:0]}), 32'(9'b101001010));
`else
        check("a5_bits", 32'(cap), 32'(10'b1101001010));
`endif

`ifdef SSER_TX_PARITY_EN
        n0 = cyc;
        wr_byte(8'h07);
        idle(FRAME + 4);
        check("par_07", 32'(hist[n0 + 2 + BD * 9 + 1]), 32'd1);
        n0 = cyc;
        wr_byte(8'h03);
        idle(FRAME + 4);
        check("par_03", 32'(hist[n0 + 2 + BD * 9 + 1]), 32'd0);
`endif

        // back-to-back: second start bit right after first stop bit
        n0 = cyc;
        wr_byte(8'h55);
        idle(3);
        wr_byte(8'hAA);
        idle(2 * FRAME + 6);
        check("b2b_stop", 32'(hist[n0 + 1 + FRAME]), 32'd1);
        check("b2b_start", 32'(hist[n0 + 2 + FRAME]), 32'd0);
        check("b2b_busy_gap", 32'(hist[n0 + 2 + FRAME + BD - 1]), 32'd0);
        rd_status();

        // overrun
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        idle(5);
        rd_status();
        rd_status();
        idle(2 * FRAME + 6);
        check("ovr_frames_ok", 32'(m_ovr), 32'd0);

        // decode qualifiers
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h5A);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h5A);
        idle(4);
        rd_status();

        // reset mid-frame
        wr_byte(8'hC3);
        idle(BD + 6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sdwr", 32'(sdwr), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; bus_stb = 1'b1; br_w = 1'b1; ba = 4'h1;
        #1;
        check("mid_rst_status", 32'(bd_out), 32'd0);
        bus_stb = 1'b0; sser_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        idle(3);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            r  = $urandom_range(0, 9);
            rb = 8'($urandom);
            if (r < 5) wr_byte(rb);
            else if (r < 7) rd_status();
            else if (r == 7) step(1'b0, 1'($urandom), 1'b1, 1'b1, 1'b0, 4'($urandom_range(1, 15)), rb);
            else idle($urandom_range(0, 50));
            idle($urandom_range(0, 20));
        end
        idle(3 * FRAME);
        rd_status();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
